// File: rtl/multiplicador_seq_pkg.sv
// rtl/multiplicador_seq_pkg.sv - shared constants and state encodings for the sequential multiplier
package mult_pkg;

    localparam int DEF_WIDTH      = 32;
    localparam int DEF_CNT_W      = 6;
    localparam int DEF_DONE_COUNT = DEF_WIDTH - 1;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // Counter value seen on the edge that performs the last add/shift
    function automatic int done_count(input int width);
        return width - 1;
    endfunction

endpackage

// File: rtl/multiplicador_seq_if.sv
// rtl/multiplicador_seq_if.sv - start/busy/done handshake shared by the multiplier and divider
interface multiplicador_seq_if
    import mult_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic                 start;
    logic [WIDTH-1:0]     mcand;
    logic [WIDTH-1:0]     mplier;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output start, mcand, mplier,
        input  busy, done, product
    );

    modport slave (
        input  start, mcand, mplier,
        output busy, done, product
    );
endinterface

// File: rtl/full_adder.sv
// rtl/full_adder.sv - one-bit full adder cell shared with the divider datapath
module Full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/multiplicador_seq_add_shift_step.sv
// rtl/multiplicador_seq_add_shift_step.sv - one conditional add plus right shift of the partial product
module add_shift_step
    import mult_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [2*WIDTH:0]   p,
    input  logic [WIDTH-1:0]   m,
    output logic [2*WIDTH:0]   p_next
);
    logic [WIDTH:0]   carry;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   upper;

    assign carry[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
        Full_adder u_fa (
            .a  (p[WIDTH+i]),
            .b  (m[i]),
            .ci (carry[i]),
            .s  (sum[i]),
            .co (carry[i+1])
        );
    end

    assign sum[WIDTH] = carry[WIDTH];

    // Carry lands in bit 2W and is pulled back into range by the shift
    assign upper  = p[0] ? sum : p[2*WIDTH:WIDTH];
    assign p_next = {1'b0, upper, p[WIDTH-1:1]};
endmodule

// File: rtl/multiplicador_seq.sv
// rtl/multiplicador_seq.sv - unsigned shift-and-add multiplier, one iteration per clock
module multiplicador_seq
    import mult_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                  clk,
    input  logic                  r,
    multiplicador_seq_if.slave    bus
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(done_count(WIDTH));

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [WIDTH-1:0]    m;
    logic [2*WIDTH:0]    p;
    logic [2*WIDTH:0]    p_next;

    add_shift_step #(.WIDTH(WIDTH)) u_step (
        .p      (p),
        .m      (m),
        .p_next (p_next)
    );

    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            state       <= IDLE;
            cnt         <= '0;
            m           <= '0;
            p           <= '0;
            bus.product <= '0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        m        <= bus.mcand;
                        p        <= {{(WIDTH+1){1'b0}}, bus.mplier};
                        cnt      <= '0;
                        state    <= RUN;
                        bus.busy <= 1'b1;
                    end
                end
                RUN: begin
                    p   <= p_next;
                    cnt <= cnt + CNT_W'(1);
                    // Product is published only once, from the final step
                    if (cnt == LAST) begin
                        state       <= DONE;
                        bus.product <= p_next[2*WIDTH-1:0];
                        bus.busy    <= 1'b0;
                        bus.done    <= 1'b1;
                    end
                end
                DONE: begin
                    bus.done <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                    bus.done <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_multiplicador_seq.sv
// tb/tb_multiplicador_seq.sv - directed self-checking bench for multiplicador_seq
module tb_multiplicador_seq;
    localparam int W = 32;

    logic clk;
    logic r;
    int   n_cmp;
    int   n_bad;

    multiplicador_seq_if #(.WIDTH(W)) bus ();

    multiplicador_seq #(.WIDTH(W), .CNT_W(6)) dut (
        .clk (clk),
        .r   (r),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issues one operation; returns one sample after the DONE->IDLE edge.
    // With hold=1 start stays high carrying 9x9 through RUN and DONE.
    task automatic op(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic [63:0] exp, input bit hold);
        int          busy_cnt;
        int          done_cnt;
        int          prod_chg;
        logic [63:0] prev;
        prev       = bus.product;
        bus.mcand  = a;
        bus.mplier = b;
        bus.start  = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_busy_accept"}, 64'(bus.busy), 64'd1);
        if (hold) begin
            bus.mcand  = 32'd9;
            bus.mplier = 32'd9;
        end else begin
            bus.start = 1'b0;
        end
        busy_cnt = 1;
        done_cnt = 0;
        prod_chg = 0;
        for (int i = 0; i < W - 1; i++) begin
            @(posedge clk); #1;
            if (bus.busy === 1'b1) busy_cnt++;
            if (bus.done !== 1'b0) done_cnt++;
            if (bus.product !== prev) prod_chg++;
        end
        chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd32);
        chk({tag, "_early_done"}, 64'(done_cnt), 64'd0);
        chk({tag, "_partial_product"}, 64'(prod_chg), 64'd0);
        @(posedge clk); #1;
        chk({tag, "_done"}, 64'(bus.done), 64'd1);
        chk({tag, "_busy_in_done"}, 64'(bus.busy), 64'd0);
        chk({tag, "_product"}, bus.product, exp);
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
        chk({tag, "_busy_after"}, 64'(bus.busy), 64'd0);
        chk({tag, "_product_hold"}, bus.product, exp);
    endtask

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        r          = 1'b1;
        bus.start  = 1'b0;
        bus.mcand  = '0;
        bus.mplier = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", 64'(bus.busy), 64'd0);
        chk("reset_done", 64'(bus.done), 64'd0);
        chk("reset_product", bus.product, 64'd0);
        r = 1'b0;
        @(posedge clk); #1;

        op("m31x108", 32'd31, 32'd108, 64'd3348, 1'b0);
        op("max_sq", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0);
        op("zero_mcand", 32'd0, 32'd12345, 64'd0, 1'b0);
        op("m3x5", 32'd3, 32'd5, 64'd15, 1'b0);
        op("zero_mplier", 32'd7, 32'd0, 64'd0, 1'b0);

        // start held through RUN and DONE; accepted only back in IDLE
        op("hold_5x6", 32'd5, 32'd6, 64'd30, 1'b1);
        op("then_9x9", 32'd9, 32'd9, 64'd81, 1'b0);

        // Asynchronous reset in the middle of an operation
        bus.mcand  = 32'd1000;
        bus.mplier = 32'd1000;
        bus.start  = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        r = 1'b1;
        #1;
        chk("async_busy", 64'(bus.busy), 64'd0);
        chk("async_done", 64'(bus.done), 64'd0);
        chk("async_product", bus.product, 64'd0);
        @(negedge clk);
        r = 1'b0;
        @(posedge clk); #1;
        op("post_reset_3x4", 32'd3, 32'd4, 64'd12, 1'b0);

        op("m2x3", 32'd2, 32'd3, 64'd6, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("idle_product", bus.product, 64'd6);
            chk("idle_done", 64'(bus.done), 64'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
